arm_controller: RTL and testbench

//  Parametrised arming FSM for the alarm subsystem; successor to the single-door arming block.

---
 rtl/arm_controller.sv | 128 ++++++++++++
 tb/tb_arm_controller.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/arm_controller.sv
// Arming FSM: N door switches, pausable countdown, remote disarm.
// Optional intrusion detection in ARMED is enabled with `define INTRUSION_EN.
module arm_controller #(
  parameter int N_DOORS = 2,
  parameter int CNT_W   = 4,
  parameter int T_ARM   = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N_DOORS-1:0] door,
  input  logic               ignicao,
  input  logic               disarm,
  input  logic [CNT_W-1:0]   t_arm,
  output logic               armar,
  output logic               armed,
  output logic               alarm,
  output logic [CNT_W-1:0]   count,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPEN  = 2'd1,
    COUNT = 2'd2,
    ARMED = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] T_DEF = CNT_W'(T_ARM);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] load;
  logic             armar_d;
  logic             alarm_d;
  logic             any_open;
  logic             intrude;
  logic             expire;

  assign any_open = |door;
  assign load     = (t_arm != '0) ? t_arm : T_DEF;
  assign expire   = !any_open && !ignicao && (count == ONE);

`ifdef INTRUSION_EN
  assign intrude = any_open | ignicao;
`else
  assign intrude = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count   <= '0;
      armar   <= 1'b0;
      armed   <= 1'b0;
      alarm   <= 1'b0;
    end else begin
      state_q <= state_d;
      count   <= count_d;
      armar   <= armar_d;
      armed   <= (state_d == ARMED);
      alarm   <= alarm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (disarm) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (any_open) state_d = OPEN;
        OPEN:    if (!any_open) state_d = COUNT;
        COUNT: begin
          if (any_open)    state_d = OPEN;
          else if (expire) state_d = ARMED;
        end
        ARMED:   state_d = ARMED;
        default: state_d = IDLE;
      endcase
    end
  end

  // Next values of the registered outputs; disarm cancels a same-cycle expiry.
  always_comb begin
    count_d = count;
    armar_d = 1'b0;
    alarm_d = alarm;
    if (disarm) begin
      count_d = '0;
      alarm_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          count_d = '0;
          alarm_d = 1'b0;
        end
        OPEN: begin
          count_d = any_open ? '0 : load;
        end
        COUNT: begin
          if (any_open) begin
            count_d = '0;
          end else if (ignicao) begin
            count_d = count;
          end else if (expire) begin
            count_d = '0;
            armar_d = 1'b1;
          end else begin
            count_d = count - ONE;
          end
        end
        ARMED: begin
          count_d = '0;
          alarm_d = alarm | intrude;
        end
        default: begin
          count_d = '0;
          alarm_d = 1'b0;
        end
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_arm_controller.sv
// Directed table-driven bench for arm_controller (N_DOORS=2, CNT_W=4, T_ARM=6).
module tb_arm_controller;

  logic       clock;
  logic       reset;
  logic [1:0] door;
  logic       ignicao;
  logic       disarm;
  logic [3:0] t_arm;
  logic       armar;
  logic       armed;
  logic       alarm;
  logic [3:0] count;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

`ifdef INTRUSION_EN
  localparam logic AL = 1'b1;
`else
  localparam logic AL = 1'b0;
`endif

  arm_controller #(.N_DOORS(2), .CNT_W(4), .T_ARM(6)) dut (
    .clock   (clock),
    .reset   (reset),
    .door    (door),
    .ignicao (ignicao),
    .disarm  (disarm),
    .t_arm   (t_arm),
    .armar   (armar),
    .armed   (armed),
    .alarm   (alarm),
    .count   (count),
    .state   (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] door;
    logic       ign;
    logic       dis;
    logic [3:0] t;
    logic [1:0] st;
    logic [3:0] cnt;
    logic       ar;
    logic       al;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic [1:0] d, logic i, logic x, logic [3:0] t,
                             logic [1:0] st, logic [3:0] c, logic ar, logic al);
    vec_t r;
    r.door = d; r.ign = i; r.dis = x; r.t = t;
    r.st = st; r.cnt = c; r.ar = ar; r.al = al;
    return r;
  endfunction

  task automatic check(string name, logic [1:0] st, logic [3:0] c,
                       logic ar, logic al);
    logic am;
    am = (st == 2'd3);
    total++;
    if (state !== st || count !== c || armar !== ar ||
        armed !== am || alarm !== al) begin
      bad++;
      $display("FAIL %s: got st=%0d cnt=%0d armar=%b armed=%b alarm=%b want st=%0d cnt=%0d armar=%b armed=%b alarm=%b",
               name, state, count, armar, armed, alarm, st, c, ar, am, al);
    end
  endtask

  task automatic drive(logic [1:0] d, logic i, logic x, logic [3:0] t);
    door = d; ignicao = i; disarm = x; t_arm = t;
  endtask

  initial begin
    // 1: default delay
    tbl.push_back(v(2'b01,0,0,0, 1,0,0,0));
    tbl.push_back(v(2'b01,0,0,0, 1,0,0,0));
    tbl.push_back(v(2'b00,0,0,0, 2,6,0,0));
    tbl.push_back(v(2'b00,0,0,0, 2,5,0,0));
    tbl.push_back(v(2'b00,0,0,0, 2,4,0,0));
    tbl.push_back(v(2'b00,0,0,0, 2,3,0,0));
    tbl.push_back(v(2'b00,0,0,0, 2,2,0,0));
    tbl.push_back(v(2'b00,0,0,0, 2,1,0,0));
    tbl.push_back(v(2'b00,0,0,0, 3,0,1,0));
    tbl.push_back(v(2'b00,0,0,0, 3,0,0,0));
    tbl.push_back(v(2'b00,0,1,0, 0,0,0,0));
    // 2: reopen mid-count, restart from 6, disarm in COUNT
    tbl.push_back(v(2'b01,0,0,0, 1,0,0,0));
    tbl.push_back(v(2'b00,0,0,0, 2,6,0,0));
    tbl.push_back(v(2'b00,0,0,0, 2,5,0,0));
    tbl.push_back(v(2'b00,0,0,0, 2,4,0,0));
    tbl.push_back(v(2'b10,0,0,0, 1,0,0,0));
    tbl.push_back(v(2'b00,0,0,0, 2,6,0,0));
    tbl.push_back(v(2'b00,0,1,0, 0,0,0,0));
    // 3: ignition pause of 4 cycles
    tbl.push_back(v(2'b01,0,0,0, 1,0,0,0));
    tbl.push_back(v(2'b00,0,0,0, 2,6,0,0));
    tbl.push_back(v(2'b00,0,0,0, 2,5,0,0));
    tbl.push_back(v(2'b00,1,0,0, 2,5,0,0));
    tbl.push_back(v(2'b00,1,0,0, 2,5,0,0));
    tbl.push_back(v(2'b00,1,0,0, 2,5,0,0));
    tbl.push_back(v(2'b00,1,0,0, 2,5,0,0));
    tbl.push_back(v(2'b00,0,0,0, 2,4,0,0));
    tbl.push_back(v(2'b00,0,0,0, 2,3,0,0));
    tbl.push_back(v(2'b00,0,0,0, 2,2,0,0));
    tbl.push_back(v(2'b00,0,0,0, 2,1,0,0));
    tbl.push_back(v(2'b00,0,0,0, 3,0,1,0));
    // 6: door / ignition activity in ARMED
    tbl.push_back(v(2'b10,0,0,0, 3,0,0,AL));
    tbl.push_back(v(2'b00,0,0,0, 3,0,0,AL));
    tbl.push_back(v(2'b00,1,0,0, 3,0,0,AL));
    tbl.push_back(v(2'b00,0,1,0, 0,0,0,0));
    // 4: runtime delay sampled only on entry
    tbl.push_back(v(2'b01,0,0,0, 1,0,0,0));
    tbl.push_back(v(2'b00,0,0,3, 2,3,0,0));
    tbl.push_back(v(2'b00,0,0,9, 2,2,0,0));
    tbl.push_back(v(2'b00,0,0,9, 2,1,0,0));
    tbl.push_back(v(2'b00,0,0,9, 3,0,1,0));
    tbl.push_back(v(2'b00,0,1,9, 0,0,0,0));
    // 5b: disarm on the expiry cycle
    tbl.push_back(v(2'b01,0,0,0, 1,0,0,0));
    tbl.push_back(v(2'b00,0,0,2, 2,2,0,0));
    tbl.push_back(v(2'b00,0,0,2, 2,1,0,0));
    tbl.push_back(v(2'b00,0,1,2, 0,0,0,0));
    tbl.push_back(v(2'b00,0,0,2, 0,0,0,0));
    // minimum delay of 1
    tbl.push_back(v(2'b01,0,0,0, 1,0,0,0));
    tbl.push_back(v(2'b00,0,0,1, 2,1,0,0));
    tbl.push_back(v(2'b00,0,0,1, 3,0,1,0));
    tbl.push_back(v(2'b00,0,0,1, 3,0,0,0));
    tbl.push_back(v(2'b00,0,1,1, 0,0,0,0));
    // disarm beats an open door
    tbl.push_back(v(2'b01,0,0,0, 1,0,0,0));
    tbl.push_back(v(2'b11,0,1,0, 0,0,0,0));
    tbl.push_back(v(2'b11,0,0,0, 1,0,0,0));
    tbl.push_back(v(2'b00,0,1,0, 0,0,0,0));
    // maximum delay with ignition held the whole time
    tbl.push_back(v(2'b01,0,0,0, 1,0,0,0));
    tbl.push_back(v(2'b00,1,0,15, 2,15,0,0));
    tbl.push_back(v(2'b00,1,0,15, 2,15,0,0));
    tbl.push_back(v(2'b00,0,0,15, 2,14,0,0));
    tbl.push_back(v(2'b00,0,1,15, 0,0,0,0));

    drive(2'b00, 0, 0, 0);
    reset = 1'b1;
    #3;
    check("reset", 2'd0, 4'd0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].door, tbl[i].ign, tbl[i].dis, tbl[i].t);
      @(negedge clock);
      check($sformatf("vec%0d", i), tbl[i].st, tbl[i].cnt, tbl[i].ar, tbl[i].al);
    end

    // async reset mid-COUNT
    drive(2'b01, 0, 0, 0);
    @(negedge clock);
    drive(2'b00, 0, 0, 0);
    @(negedge clock);
    @(negedge clock);
    check("pre_rst_count", 2'd2, 4'd5, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1 check("rst_in_count", 2'd0, 4'd0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b0;

    // async reset on the armar cycle in ARMED
    drive(2'b01, 0, 0, 0);
    @(negedge clock);
    drive(2'b00, 0, 0, 1);
    @(negedge clock);
    @(negedge clock);
    check("pre_rst_armed", 2'd3, 4'd0, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1 check("rst_in_armed", 2'd0, 4'd0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("idle_after_rst", 2'd0, 4'd0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
